// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage MIPS pipeline: E/M/W writer scoreboard with Tnew countdown,
// Tuse-based stall, forwarding selects for D/E/M consumers, and a multi-cycle MDU busy counter.
module hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md,
  input  logic              d_md_start,
  input  logic              d_md_div,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt,
  output logic              md_busy
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] dst;
    logic [TW-1:0]     tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              md_start;
    logic              md_div;
  } entry_t;

  localparam logic [TW-1:0]    T_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  entry_t           e_q, m_q, w_q;
  entry_t           e_nxt, m_nxt, w_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic             src_stall, md_stall;

  function automatic logic writes(entry_t ent, logic [REG_AW-1:0] r);
    return ent.valid && ent.we && (ent.dst == r) && (r != '0);
  endfunction

  function automatic logic [TW-1:0] dec_sat(logic [TW-1:0] t);
    return (t == '0) ? '0 : t - T_ONE;
  endfunction

  // Youngest writer wins; a writer whose result is not ready yet yields 0 (stall covers it).
  function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] r, entry_t e, entry_t m, entry_t w,
                                         logic incl_e, logic incl_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (incl_e && writes(e, r))      sel = (e.tnew == '0) ? 2'd3 : 2'd0;
    else if (incl_m && writes(m, r)) sel = (m.tnew == '0) ? 2'd2 : 2'd0;
    else if (writes(w, r))           sel = (w.tnew == '0) ? 2'd1 : 2'd0;
    return sel;
  endfunction

  function automatic logic need_stall(logic use_s, logic [REG_AW-1:0] r, logic [TW-1:0] tuse,
                                      entry_t e, entry_t m);
    return use_s && ((writes(e, r) && (e.tnew > tuse)) || (writes(m, r) && (m.tnew > tuse)));
  endfunction

  assign md_busy   = (md_cnt != '0);
  assign md_stall  = d_md && (md_busy || (e_q.valid && e_q.md_start));
  assign src_stall = need_stall(d_use_rs, d_rs, d_tuse_rs, e_q, m_q) ||
                     need_stall(d_use_rt, d_rt, d_tuse_rt, e_q, m_q);
  assign stall     = src_stall || md_stall;

  assign fwd_d_rs = fwd_sel(d_rs, e_q, m_q, w_q, 1'b1, 1'b1);
  assign fwd_d_rt = fwd_sel(d_rt, e_q, m_q, w_q, 1'b1, 1'b1);
  assign fwd_e_rs = fwd_sel(e_q.rs, e_q, m_q, w_q, 1'b0, 1'b1);
  assign fwd_e_rt = fwd_sel(e_q.rt, e_q, m_q, w_q, 1'b0, 1'b1);
  assign fwd_m_rt = fwd_sel(m_q.rt, e_q, m_q, w_q, 1'b0, 1'b0);

  always_comb begin
    e_nxt = '0;
    if (!stall) begin
      e_nxt.valid    = 1'b1;
      e_nxt.we       = d_we;
      e_nxt.dst      = d_dst;
      e_nxt.tnew     = d_tnew;
      e_nxt.rs       = d_rs;
      e_nxt.rt       = d_rt;
      e_nxt.md_start = d_md_start;
      e_nxt.md_div   = d_md_div;
    end
    m_nxt      = e_q;
    m_nxt.tnew = dec_sat(e_q.tnew);
    w_nxt      = m_q;
    w_nxt.tnew = dec_sat(m_q.tnew);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      md_cnt <= '0;
    end else begin
      e_q <= e_nxt;
      m_q <= m_nxt;
      w_q <= w_nxt;
      // A new MDU op overwrites any residual count.
      if (e_q.valid && e_q.md_start)
        md_cnt <= e_q.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random D-stage traffic,
// checked against a cycle-history model of which instruction occupies each stage.
module tb_hazard_scoreboard;

  logic       clk, reset_n;
  logic [4:0] d_rs, d_rt, d_dst;
  logic       d_use_rs, d_use_rt, d_we, d_md, d_md_start, d_md_div;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_dst(d_dst),
    .d_tnew(d_tnew), .d_md(d_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // hist[c] is the instruction that sat in E during cycle c; M and W are c-1 and c-2.
  typedef struct {
    bit v, we, ms, mdv;
    int dst, tnew, rs, rt;
  } ins_t;

  ins_t hist [0:8191];
  ins_t empty_i;
  int   cyc = 0;
  int   base = 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic ins_t stg(int k);
    if (cyc - k >= base) return hist[cyc - k];
    return empty_i;
  endfunction

  function automatic int tn(ins_t i, int k);
    return (i.tnew > k) ? i.tnew - k : 0;
  endfunction

  function automatic bit wr(ins_t i, int r);
    return i.v && i.we && (i.dst == r) && (r != 0);
  endfunction

  function automatic int fsel(int r, int k0);
    for (int k = k0; k <= 2; k++) begin
      ins_t i;
      i = stg(k);
      if (wr(i, r)) return (tn(i, k) == 0) ? 3 - k : 0;
    end
    return 0;
  endfunction

  // The MDU is busy for N cycles after the cycle in which the latest start sat in E.
  function automatic bit mdbusy();
    for (int s = cyc - 1; s >= base && s >= cyc - 12; s--) begin
      if (hist[s].v && hist[s].ms) return cyc <= s + (hist[s].mdv ? 10 : 5);
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit   st;
    ins_t e0;
    st = 0;
    e0 = stg(0);
    for (int k = 0; k < 2; k++) begin
      ins_t i;
      i = stg(k);
      if (d_use_rs && wr(i, int'(d_rs)) && tn(i, k) > int'(d_tuse_rs)) st = 1;
      if (d_use_rt && wr(i, int'(d_rt)) && tn(i, k) > int'(d_tuse_rt)) st = 1;
    end
    if (d_md && (mdbusy() || (e0.v && e0.ms))) st = 1;
    return st;
  endfunction

  task automatic set_d(int rs, int rt, bit urs, bit urt, int trs, int trt,
                       bit we, int dst, int tnew, bit md, bit ms, bit mdiv);
    d_rs = 5'(rs); d_rt = 5'(rt); d_use_rs = urs; d_use_rt = urt;
    d_tuse_rs = 2'(trs); d_tuse_rt = 2'(trt); d_we = we; d_dst = 5'(dst);
    d_tnew = 2'(tnew); d_md = md; d_md_start = ms; d_md_div = mdiv;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check every output against the model mid-cycle, then advance one edge.
  task automatic tick();
    bit   es;
    ins_t e0, m0, ni;
    @(negedge clk);
    es = exp_stall();
    e0 = stg(0);
    m0 = stg(1);
    chk("m_stall",    32'(stall),    32'(es));
    chk("m_fwd_d_rs", 32'(fwd_d_rs), fsel(int'(d_rs), 0));
    chk("m_fwd_d_rt", 32'(fwd_d_rt), fsel(int'(d_rt), 0));
    chk("m_fwd_e_rs", 32'(fwd_e_rs), fsel(e0.rs, 1));
    chk("m_fwd_e_rt", 32'(fwd_e_rt), fsel(e0.rt, 1));
    chk("m_fwd_m_rt", 32'(fwd_m_rt), fsel(m0.rt, 2));
    chk("m_md_busy",  32'(md_busy),  32'(mdbusy()));
    ni = empty_i;
    if (!es) begin
      ni.v = 1; ni.we = d_we; ni.dst = int'(d_dst); ni.tnew = int'(d_tnew);
      ni.rs = int'(d_rs); ni.rt = int'(d_rt); ni.ms = d_md_start; ni.mdv = d_md_div;
    end
    @(posedge clk);
    hist[cyc + 1] = ni;
    cyc++;
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_busy"},  32'(md_busy), 0);
    chk({tag, "_d_rs"},  32'(fwd_d_rs), 0);
    chk({tag, "_d_rt"},  32'(fwd_d_rt), 0);
    chk({tag, "_e_rs"},  32'(fwd_e_rs), 0);
    chk({tag, "_e_rt"},  32'(fwd_e_rt), 0);
    chk({tag, "_m_rt"},  32'(fwd_m_rt), 0);
  endtask

  task automatic count_md_stall(bit div, output int n, output int b);
    set_d(6, 7, 1, 1, 1, 1, 0, 0, 0, 1, 1, div);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0);
    n = 0;
    b = 0;
    #1;
    while (stall === 1'b1 && n < 20) begin
      n++;
      if (md_busy === 1'b1) b++;
      tick();
    end
    tick();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    int n, b;
    reset_n = 1'b0;
    set_d(1, 2, 1, 1, 0, 0, 1, 3, 2, 1, 1, 0);
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = cyc + 1;
    nop();

    // ALU result feeding a branch compare in D
    set_d(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tick();
    set_d(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("alu_br_stall", 32'(stall), 1);
    tick();
    chk("alu_br_release", 32'(stall), 0);
    chk("alu_br_fwd", 32'(fwd_d_rs), 2);
    tick();
    nop();
    repeat (3) tick();

    // Load-use with a following ALU consumer
    set_d(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    tick();
    set_d(2, 3, 1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    #1 chk("ld_use_stall", 32'(stall), 1);
    tick();
    chk("ld_use_release", 32'(stall), 0);
    tick();
    chk("ld_use_fwd_e", 32'(fwd_e_rs), 1);
    nop();
    repeat (3) tick();

    // Load then store of the loaded register: data reaches the store in M from W
    set_d(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    tick();
    set_d(0, 2, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    #1 chk("ld_sw_stall", 32'(stall), 0);
    tick();
    nop();
    tick();
    chk("ld_sw_fwd_m", 32'(fwd_m_rt), 1);
    repeat (3) tick();

    // lui result is ready in E
    set_d(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    set_d(3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lui_stall", 32'(stall), 0);
    chk("lui_fwd_rs", 32'(fwd_d_rs), 3);
    chk("lui_fwd_rt", 32'(fwd_d_rt), 3);
    tick();
    nop();
    repeat (3) tick();

    // Two writers of $5: youngest (E) wins
    set_d(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    tick();
    set_d(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("dbl_stall", 32'(stall), 0);
    chk("dbl_fwd", 32'(fwd_d_rs), 3);
    tick();

    // Loads targeting $0 in E/M/W never stall or forward
    set_d(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    repeat (3) tick();
    set_d(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r0_stall", 32'(stall), 0);
    chk("r0_d_rs", 32'(fwd_d_rs), 0);
    chk("r0_d_rt", 32'(fwd_d_rt), 0);
    chk("r0_e_rs", 32'(fwd_e_rs), 0);
    chk("r0_m_rt", 32'(fwd_m_rt), 0);
    tick();
    nop();
    repeat (3) tick();

    // MDU: mult then mflo, div then mflo
    count_md_stall(1'b0, n, b);
    chk("mult_stall_cycles", n, 6);
    chk("mult_busy_cycles", b, 5);
    count_md_stall(1'b1, n, b);
    chk("div_stall_cycles", n, 11);
    chk("div_busy_cycles", b, 10);

    // Reset in the middle of a divide (counter at 7)
    set_d(6, 7, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0);
    repeat (4) tick();
    chk("rst_pre_busy", 32'(md_busy), 1);
    chk("rst_pre_stall", 32'(stall), 1);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = cyc + 1;
    set_d(5, 6, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 chk_all_zero("rst_after");
    repeat (3) tick();

    // Random D-stage traffic over a small register set
    for (int i = 0; i < 1500; i++) begin
      bit md, ms;
      md = ($urandom_range(0, 7) == 0);
      ms = md && ($urandom_range(0, 2) == 0);
      set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), md, ms, ($urandom_range(0, 1) == 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
